// File: rtl/decode_stage.sv
// Multi-lane RV32 decode stage: per-lane combinational decode feeding a group-wide
// output register backed by a one-entry skid buffer, with flush and illegal detection.
module decode_stage #(
   parameter int unsigned LANES = 2,
   parameter int unsigned XLEN  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES-1:0]       in_lane_mask,
   input  logic [32*LANES-1:0]    in_instr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES-1:0]       out_lane_valid,
   output logic [7*LANES-1:0]     out_opcode,
   output logic [5*LANES-1:0]     out_rd,
   output logic [5*LANES-1:0]     out_rs1,
   output logic [5*LANES-1:0]     out_rs2,
   output logic [3*LANES-1:0]     out_func3,
   output logic [XLEN*LANES-1:0]  out_imm,
   output logic [LANES-1:0]       out_loadstore,
   output logic [LANES-1:0]       out_alusrc,
   output logic [LANES-1:0]       out_regwrite,
   output logic [LANES-1:0]       out_bms,
   output logic [LANES-1:0]       out_illegal,
   output logic [4*LANES-1:0]     out_aluctrl
);

   localparam logic [3:0] AluNone = 4'b0000;
   localparam logic [3:0] AluOr   = 4'b0001;
   localparam logic [3:0] AluAdd  = 4'b0010;
   localparam logic [3:0] AluXor  = 4'b0011;
   localparam logic [3:0] AluSra  = 4'b1011;

   localparam logic [6:0] OpReg   = 7'b0110011;
   localparam logic [6:0] OpImm   = 7'b0010011;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpLui   = 7'b0110111;

   typedef struct packed {
      logic            vld;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      func3;
      logic [XLEN-1:0] imm;
      logic            loadstore;
      logic            alusrc;
      logic            regwrite;
      logic            bms;
      logic            illegal;
      logic [3:0]      aluctrl;
   } lane_t;

   function automatic lane_t decode_lane(input logic present, input logic [31:0] ins);
      lane_t d;
      d = '0;
      if (present) begin
         d.vld    = 1'b1;
         d.opcode = ins[6:0];
         d.rd     = ins[11:7];
         d.func3  = ins[14:12];
         d.rs1    = ins[19:15];
         d.rs2    = ins[24:20];
         case (ins[6:0])
            OpReg: begin
               if (ins[31:25] == 7'b0000000 && ins[14:12] == 3'b000) begin
                  d.aluctrl  = AluAdd;
                  d.regwrite = 1'b1;
               end else if (ins[31:25] == 7'b0000000 && ins[14:12] == 3'b100) begin
                  d.aluctrl  = AluXor;
                  d.regwrite = 1'b1;
               end else begin
                  d.illegal = 1'b1;
               end
            end
            OpImm: begin
               case (ins[14:12])
                  3'b000: begin
                     d.aluctrl = AluAdd;
                     d.imm     = XLEN'($signed(ins[31:20]));
                  end
                  3'b110: begin
                     d.aluctrl = AluOr;
                     d.imm     = XLEN'($signed(ins[31:20]));
                  end
                  3'b101: begin
                     if (ins[31:25] == 7'b0100000) begin
                        d.aluctrl = AluSra;
                        d.imm     = XLEN'(ins[24:20]);
                     end else begin
                        d.illegal = 1'b1;
                     end
                  end
                  default: d.illegal = 1'b1;
               endcase
               d.alusrc   = !d.illegal;
               d.regwrite = !d.illegal;
            end
            OpLoad, OpStore: begin
               if (ins[14:12] == 3'b000 || ins[14:12] == 3'b010) begin
                  d.loadstore = 1'b1;
                  d.alusrc    = 1'b1;
                  d.aluctrl   = AluAdd;
                  // Byte access selected straight from this instruction's func3
                  d.bms       = (ins[14:12] == 3'b000);
                  d.regwrite  = (ins[6:0] == OpLoad);
                  d.imm       = (ins[6:0] == OpLoad) ? XLEN'($signed(ins[31:20]))
                                                     : XLEN'($signed({ins[31:25], ins[11:7]}));
               end else begin
                  d.illegal = 1'b1;
               end
            end
            OpLui: begin
               d.imm      = XLEN'({ins[31:12], 12'b0});
               d.alusrc   = 1'b1;
               d.regwrite = 1'b1;
               d.aluctrl  = AluNone;
            end
            default: d.illegal = (ins != 32'h0000_0000);
         endcase
      end
      return d;
   endfunction

   lane_t [LANES-1:0] dec;
   lane_t [LANES-1:0] out_q, out_d;
   lane_t [LANES-1:0] skid_q, skid_d;
   logic              out_valid_q, out_valid_d;
   logic              skid_full_q, skid_full_d;
   logic              in_ready_q;
   logic              accept, out_free;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         dec[i] = decode_lane(in_lane_mask[i], in_instr[32*i +: 32]);
      end
   end

   assign accept   = in_valid & in_ready_q;
   assign out_free = !out_valid_q | out_ready;

   always_comb begin
      out_d       = out_q;
      skid_d      = skid_q;
      out_valid_d = out_valid_q;
      skid_full_d = skid_full_q;
      if (out_free) begin
         if (skid_full_q) begin
            out_d       = skid_q;
            out_valid_d = 1'b1;
            skid_full_d = 1'b0;
         end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d      = dec;
         skid_full_d = 1'b1;
      end
      if (flush) begin
         out_d       = '0;
         skid_d      = '0;
         out_valid_d = 1'b0;
         skid_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         skid_full_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         out_q       <= out_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         skid_full_q <= skid_full_d;
         in_ready_q  <= !skid_full_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;

   for (genvar g = 0; g < LANES; g++) begin : g_out
      assign out_lane_valid[g]         = out_q[g].vld;
      assign out_opcode[7*g +: 7]      = out_q[g].opcode;
      assign out_rd[5*g +: 5]          = out_q[g].rd;
      assign out_rs1[5*g +: 5]         = out_q[g].rs1;
      assign out_rs2[5*g +: 5]         = out_q[g].rs2;
      assign out_func3[3*g +: 3]       = out_q[g].func3;
      assign out_imm[XLEN*g +: XLEN]   = out_q[g].imm;
      assign out_loadstore[g]          = out_q[g].loadstore;
      assign out_alusrc[g]             = out_q[g].alusrc;
      assign out_regwrite[g]           = out_q[g].regwrite;
      assign out_bms[g]                = out_q[g].bms;
      assign out_illegal[g]            = out_q[g].illegal;
      assign out_aluctrl[4*g +: 4]     = out_q[g].aluctrl;
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (LANES=2): expected groups are queued on accept
// and compared field by field when the stage hands a group downstream.
module tb_decode_stage;

   localparam int LANES = 2;
   localparam int NV    = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  in_lane_mask = '0;
   logic [63:0] in_instr = '0;
   logic        in_ready, out_valid;
   logic [1:0]  out_lane_valid, out_loadstore, out_alusrc, out_regwrite, out_bms, out_illegal;
   logic [13:0] out_opcode;
   logic [9:0]  out_rd, out_rs1, out_rs2;
   logic [5:0]  out_func3;
   logic [63:0] out_imm;
   logic [7:0]  out_aluctrl;

   decode_stage #(.LANES(LANES), .XLEN(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_lane_mask(in_lane_mask),
      .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
      .out_lane_valid(out_lane_valid), .out_opcode(out_opcode), .out_rd(out_rd),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_func3(out_func3), .out_imm(out_imm),
      .out_loadstore(out_loadstore), .out_alusrc(out_alusrc), .out_regwrite(out_regwrite),
      .out_bms(out_bms), .out_illegal(out_illegal), .out_aluctrl(out_aluctrl)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        vld;
      logic [6:0]  opcode;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  func3;
      logic [31:0] imm;
      logic        ls, alusrc, rw, bms, ill;
      logic [3:0]  alu;
   } exp_lane_t;
   typedef exp_lane_t [1:0] exp_grp_t;

   // ctl = {loadstore, alusrc, regwrite, bms, illegal}
   typedef struct packed {
      logic [31:0] w;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [4:0]  ctl;
   } vec_t;

   vec_t     tbl [NV];
   exp_grp_t sb[$];
   int       total = 0;
   int       bad = 0;
   int       n_out = 0;
   logic     acc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_lane_t expect_lane(input logic present, input logic [31:0] w);
      exp_lane_t e;
      e = '0;
      if (present) begin
         e.vld    = 1'b1;
         e.opcode = w[6:0];
         e.rd     = w[11:7];
         e.func3  = w[14:12];
         e.rs1    = w[19:15];
         e.rs2    = w[24:20];
         for (int k = 0; k < NV; k++) begin
            if (tbl[k].w == w) begin
               e.imm = tbl[k].imm;
               e.alu = tbl[k].alu;
               {e.ls, e.alusrc, e.rw, e.bms, e.ill} = tbl[k].ctl;
            end
         end
      end
      return e;
   endfunction

   function automatic exp_grp_t make_group(input logic [1:0] m, input logic [31:0] i0,
                                           input logic [31:0] i1);
      exp_grp_t g;
      g[0] = expect_lane(m[0], i0);
      g[1] = expect_lane(m[1], i1);
      return g;
   endfunction

   task automatic compare_group(input exp_grp_t e);
      for (int l = 0; l < LANES; l++) begin
         check($sformatf("g%0d_l%0d_vld", n_out, l), 32'(out_lane_valid[l]), 32'(e[l].vld));
         check($sformatf("g%0d_l%0d_opcode", n_out, l), 32'(out_opcode[7*l +: 7]), 32'(e[l].opcode));
         check($sformatf("g%0d_l%0d_rd", n_out, l), 32'(out_rd[5*l +: 5]), 32'(e[l].rd));
         check($sformatf("g%0d_l%0d_rs1", n_out, l), 32'(out_rs1[5*l +: 5]), 32'(e[l].rs1));
         check($sformatf("g%0d_l%0d_rs2", n_out, l), 32'(out_rs2[5*l +: 5]), 32'(e[l].rs2));
         check($sformatf("g%0d_l%0d_func3", n_out, l), 32'(out_func3[3*l +: 3]), 32'(e[l].func3));
         check($sformatf("g%0d_l%0d_imm", n_out, l), out_imm[32*l +: 32], e[l].imm);
         check($sformatf("g%0d_l%0d_ls", n_out, l), 32'(out_loadstore[l]), 32'(e[l].ls));
         check($sformatf("g%0d_l%0d_alusrc", n_out, l), 32'(out_alusrc[l]), 32'(e[l].alusrc));
         check($sformatf("g%0d_l%0d_rw", n_out, l), 32'(out_regwrite[l]), 32'(e[l].rw));
         check($sformatf("g%0d_l%0d_bms", n_out, l), 32'(out_bms[l]), 32'(e[l].bms));
         check($sformatf("g%0d_l%0d_ill", n_out, l), 32'(out_illegal[l]), 32'(e[l].ill));
         check($sformatf("g%0d_l%0d_alu", n_out, l), 32'(out_aluctrl[4*l +: 4]), 32'(e[l].alu));
      end
   endtask

   // Drive one cycle's inputs at the falling edge, settle, then score the handshakes.
   task automatic step(input logic v, input logic [1:0] m, input logic [31:0] i0,
                       input logic [31:0] i1, input logic ordy, input logic fl, input logic rs);
      in_valid = v; in_lane_mask = m; in_instr = {i1, i0};
      out_ready = ordy; flush = fl; reset = rs;
      #1;
      acc = in_valid && in_ready;
      if (rs) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_group", 32'd1, 32'd0);
            else compare_group(sb.pop_front());
            n_out++;
         end
         if (fl) sb.delete();
         else if (acc) sb.push_back(make_group(m, i0, i1));
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 2'b00, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((sb.size() != 0 || out_valid) && guard < 20) begin
         idle(1'b1);
         guard++;
      end
      check("drain_bound", 32'(guard < 20), 32'd1);
      check("sb_empty", sb.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      tbl[0]  = {32'hFFF00093, 32'hFFFFFFFF, 4'h2, 5'b01100};
      tbl[1]  = {32'h123452B7, 32'h12345000, 4'h0, 5'b01100};
      tbl[2]  = {32'h40725193, 32'h00000007, 4'hB, 5'b01100};
      tbl[3]  = {32'h0020A423, 32'h00000008, 4'h2, 5'b11000};
      tbl[4]  = {32'h00208423, 32'h00000008, 4'h2, 5'b11010};
      tbl[5]  = {32'h0000006F, 32'h00000000, 4'h0, 5'b00001};
      tbl[6]  = {32'h00000000, 32'h00000000, 4'h0, 5'b00000};
      tbl[7]  = {32'h002081B3, 32'h00000000, 4'h2, 5'b00100};
      tbl[8]  = {32'h0020C1B3, 32'h00000000, 4'h3, 5'b00100};
      tbl[9]  = {32'h402081B3, 32'h00000000, 4'h0, 5'b00001};
      tbl[10] = {32'h0FF0E093, 32'h000000FF, 4'h1, 5'b01100};
      tbl[11] = {32'h80002083, 32'hFFFFF800, 4'h2, 5'b11100};
      tbl[12] = {32'h00001003, 32'h00000000, 4'h0, 5'b00001};
      tbl[13] = {32'h00725193, 32'h00000000, 4'h0, 5'b00001};
      tbl[14] = {32'hFE20AE23, 32'hFFFFFFFC, 4'h2, 5'b11000};

      @(negedge clk);
      for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_ovalid", 32'(out_valid), 32'd0);
      check("rst_imm", out_imm[31:0], 32'd0);
      check("rst_lane_valid", 32'(out_lane_valid), 32'd0);
      idle(1'b0);
      check("ready_after_rst", 32'(in_ready), 32'd1);

      // Directed groups, back to back at full rate
      step(1'b1, 2'b11, tbl[0].w, tbl[1].w, 1'b1, 1'b0, 1'b0);
      check("rate_acc0", 32'(acc), 32'd1);
      step(1'b1, 2'b01, tbl[2].w, tbl[6].w, 1'b1, 1'b0, 1'b0);
      check("rate_acc1", 32'(acc), 32'd1);
      step(1'b1, 2'b01, tbl[3].w, tbl[6].w, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'b01, tbl[4].w, tbl[6].w, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'b11, tbl[5].w, tbl[6].w, 1'b1, 1'b0, 1'b0);
      for (int k = 7; k < NV; k++) begin
         step(1'b1, 2'(k % 3 + 1), tbl[k].w, tbl[NV - 1 - (k - 7)].w, 1'b1, 1'b0, 1'b0);
         check($sformatf("rate_acc_k%0d", k), 32'(acc), 32'd1);
      end
      drain();

      // Random traffic with random backpressure
      for (int c = 0; c < 60; c++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              tbl[$urandom_range(0, NV - 1)].w, tbl[$urandom_range(0, NV - 1)].w,
              1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      drain();

      // Stall with A on output: B lands in skid, C waits; order must be A, B, C
      n0 = n_out;
      step(1'b1, 2'b11, tbl[0].w, tbl[1].w, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'b11, tbl[2].w, tbl[3].w, 1'b0, 1'b0, 1'b0);
      check("stall_b_acc", 32'(acc), 32'd1);
      check("stall_ready", 32'(in_ready), 32'd0);
      check("stall_ovalid", 32'(out_valid), 32'd1);
      step(1'b1, 2'b11, tbl[4].w, tbl[14].w, 1'b0, 1'b0, 1'b0);
      check("stall_c_blocked", 32'(acc), 32'd0);
      step(1'b1, 2'b11, tbl[4].w, tbl[14].w, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'b11, tbl[4].w, tbl[14].w, 1'b1, 1'b0, 1'b0);
      check("release_c_acc", 32'(acc), 32'd1);
      drain();
      check("stall_group_count", n_out - n0, 32'd3);

      // Flush with output and skid both full
      step(1'b1, 2'b11, tbl[7].w, tbl[8].w, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'b11, tbl[10].w, tbl[11].w, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'b11, tbl[2].w, tbl[3].w, 1'b0, 1'b1, 1'b0);
      check("flush_ovalid", 32'(out_valid), 32'd0);
      check("flush_ready", 32'(in_ready), 32'd1);
      // Flush while a group is accepted in the same cycle: that group is dropped
      step(1'b1, 2'b11, tbl[7].w, tbl[8].w, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'b11, tbl[14].w, tbl[0].w, 1'b0, 1'b1, 1'b0);
      check("flush_acc", 32'(acc), 32'd1);
      check("flush_drop_ovalid", 32'(out_valid), 32'd0);
      idle(1'b1);
      check("flush_drop_stays", 32'(out_valid), 32'd0);
      n0 = n_out;
      step(1'b1, 2'b11, tbl[11].w, tbl[4].w, 1'b1, 1'b0, 1'b0);
      drain();
      check("after_flush_d", n_out - n0, 32'd1);

      // Reset in the middle of a stall drops both held groups
      step(1'b1, 2'b11, tbl[0].w, tbl[1].w, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'b11, tbl[2].w, tbl[3].w, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'b11, tbl[4].w, tbl[5].w, 1'b0, 1'b0, 1'b1);
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      check("mid_rst_ovalid", 32'(out_valid), 32'd0);
      check("mid_rst_imm", out_imm[63:32], 32'd0);
      check("mid_rst_lane_valid", 32'(out_lane_valid), 32'd0);
      check("mid_rst_rw", 32'(out_regwrite), 32'd0);
      check("mid_rst_alu", 32'(out_aluctrl), 32'd0);
      idle(1'b1);
      check("mid_rst_ready_after", 32'(in_ready), 32'd1);
      check("mid_rst_ovalid_after", 32'(out_valid), 32'd0);
      n0 = n_out;
      step(1'b1, 2'b10, tbl[6].w, tbl[10].w, 1'b1, 1'b0, 1'b0);
      drain();
      check("after_rst_group", n_out - n0, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
